// File: rtl/gate_chk_pkg.sv
// ============================================================================
// Module : gate_chk_pkg
// Brief  : Shared state encoding and response bit map for the gate checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  localparam int N_VECTORS = 16;

  localparam int IDX_AND  = 0;
  localparam int IDX_NAND = 1;
  localparam int IDX_OR   = 2;
  localparam int IDX_NOR  = 3;
  localparam int IDX_XOR  = 4;
  localparam int IDX_XNOR = 5;
  localparam int IDX_NOT  = 6;
  localparam int IDX_BUF  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// Module : gate_ref_model
// Brief  : Combinational golden response of the 4-input gate block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [3:0] i_vec,
  output logic [7:0] o_expected
);

  always_comb begin
    o_expected           = 8'h00;
    o_expected[IDX_AND]  = &i_vec;
    o_expected[IDX_NAND] = ~&i_vec;
    o_expected[IDX_OR]   = |i_vec;
    o_expected[IDX_NOR]  = ~|i_vec;
    o_expected[IDX_XOR]  = ^i_vec;
    o_expected[IDX_XNOR] = ~^i_vec;
    o_expected[IDX_NOT]  = ~i_vec[0];
    o_expected[IDX_BUF]  = i_vec[0];
  end

endmodule

`default_nettype wire

// File: rtl/gate_vector_checker.sv
// ============================================================================
// Module : gate_vector_checker
// Brief  : Sweeps all 16 input vectors through a gate block and scores resp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [3:0] stim,
  input  logic [7:0] resp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic [7:0] first_fail_mask
);

  localparam bit         c_skip_settle = (SETTLE_CYCLES == 0);
  localparam logic [3:0] c_settle_last = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_last_vec    = 4'(N_VECTORS - 1);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_stim;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [4:0] r_err;
  logic [3:0] r_ffv;
  logic [7:0] r_ffm;

  logic [7:0] w_expected;
  logic [7:0] w_diff;
  logic       w_mismatch;
  logic [4:0] w_err_next;

  gate_ref_model u_ref (
    .i_vec      (r_stim),
    .o_expected (w_expected)
  );

  assign w_diff     = w_expected ^ resp;
  assign w_mismatch = |w_diff;
  assign w_err_next = r_err + {4'd0, w_mismatch};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_stim  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 5'd0;
      r_ffv   <= 4'd0;
      r_ffm   <= 8'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= c_skip_settle ? SAMPLE : SETTLE;
            r_cnt   <= 4'd0;
            r_stim  <= 4'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 5'd0;
            r_ffv   <= 4'd0;
            r_ffm   <= 8'd0;
          end
        end
        SETTLE: begin
          if (r_cnt == c_settle_last) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          r_err <= w_err_next;
          // Only the very first mismatch of a run is captured.
          if (w_mismatch && (r_err == 5'd0)) begin
            r_ffv <= r_stim;
            r_ffm <= w_diff;
          end
          if (r_stim == c_last_vec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 5'd0);
          end else begin
            r_stim  <= r_stim + 4'd1;
            r_cnt   <= 4'd0;
            r_state <= c_skip_settle ? SAMPLE : SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim            = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_vec  = r_ffv;
  assign first_fail_mask = r_ffm;

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
// ============================================================================
// Module : tb_gate_vector_checker
// Brief  : Self-checking bench running three checkers (settle 0/1/3) in parallel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_vector_checker;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;

  logic [3:0] stim_a [3];
  logic [7:0] resp_a [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       pass_a [3];
  logic [4:0] err_a  [3];
  logic [3:0] ffv_a  [3];
  logic [7:0] ffm_a  [3];

  int         mode = 0;
  logic [7:0] flip_tbl [16];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      gate_vector_checker #(.SETTLE_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .stim            (stim_a[g]),
        .resp            (resp_a[g]),
        .busy            (busy_a[g]),
        .done            (done_a[g]),
        .pass            (pass_a[g]),
        .err_count       (err_a[g]),
        .first_fail_vec  (ffv_a[g]),
        .first_fail_mask (ffm_a[g])
      );
    end
  endgenerate

  function automatic int settle_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  // Golden gate truth derived from the count of ones in the vector.
  function automatic logic [7:0] ref_exp(input logic [3:0] v);
    int ones;
    logic [7:0] r;
    ones = $countones(v);
    r[0] = (ones == 4);
    r[1] = (ones != 4);
    r[2] = (ones != 0);
    r[3] = (ones == 0);
    r[4] = (ones % 2 == 1);
    r[5] = (ones % 2 == 0);
    r[6] = (v[0] == 1'b0);
    r[7] = (v[0] == 1'b1);
    return r;
  endfunction

  function automatic logic [7:0] gate_block(input logic [3:0] v, input int m, input logic [7:0] flip);
    logic [7:0] e;
    e = ref_exp(v);
    case (m)
      1:       return e & 8'hEF;
      2:       return {e[6], e[7], e[5:0]};
      3:       return e ^ flip;
      default: return e;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      resp_a[k] = gate_block(stim_a[k], mode, flip_tbl[stim_a[k]]);
    end
  end

  task automatic check_idle(input string name);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stim_a[k] !== 4'd0 || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || pass_a[k] !== 1'b0 ||
          err_a[k] !== 5'd0 || ffv_a[k] !== 4'd0 || ffm_a[k] !== 8'd0) begin
        errors++;
        $display("FAIL %s dut%0d: got stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffm=%h, required all zero",
                 name, k, stim_a[k], busy_a[k], done_a[k], pass_a[k], err_a[k], ffv_a[k], ffm_a[k]);
      end
    end
  endtask

  // Starts a run (pulse or held start) and checks timing, stim sweep and results.
  task automatic run_and_check(input string name, input bit hold);
    int exp_err;
    logic [3:0] exp_ffv;
    logic [7:0] exp_ffm;
    logic [7:0] d;
    exp_err = 0; exp_ffv = 0; exp_ffm = 0;
    for (int v = 0; v < 16; v++) begin
      d = gate_block(4'(v), mode, flip_tbl[v]) ^ ref_exp(4'(v));
      if (d != 8'd0) begin
        if (exp_err == 0) begin exp_ffv = 4'(v); exp_ffm = d; end
        exp_err++;
      end
    end
    start = 1'b1;
    for (int n = 1; n <= 67; n++) begin
      @(posedge CLK); #1;
      if (n == 1 && !hold) start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int s, len;
        s = settle_of(k);
        len = 16 * (s + 1);
        if (n <= len) begin
          checks++;
          if (busy_a[k] !== 1'b1 || done_a[k] !== 1'b0 || stim_a[k] !== 4'((n - 1) / (s + 1))) begin
            errors++;
            $display("FAIL %s seq dut%0d n=%0d: got busy=%b done=%b stim=%0d, required busy=1 done=0 stim=%0d",
                     name, k, n, busy_a[k], done_a[k], stim_a[k], (n - 1) / (s + 1));
          end
        end else if (n == len + 1 || (!hold && n == 67)) begin
          checks++;
          if (done_a[k] !== 1'b1 || busy_a[k] !== 1'b0 || stim_a[k] !== 4'd15 ||
              pass_a[k] !== (exp_err == 0) || err_a[k] !== 5'(exp_err) ||
              ffv_a[k] !== exp_ffv || ffm_a[k] !== exp_ffm) begin
            errors++;
            $display("FAIL %s result dut%0d n=%0d: got done=%b busy=%b stim=%0d pass=%b err=%0d ffv=%0d ffm=%h, required 1 0 15 %b %0d %0d %h",
                     name, k, n, done_a[k], busy_a[k], stim_a[k], pass_a[k], err_a[k], ffv_a[k], ffm_a[k],
                     (exp_err == 0), exp_err, exp_ffv, exp_ffm);
          end
        end else if (hold && n == len + 2) begin
          checks++;
          if (busy_a[k] !== 1'b1 || done_a[k] !== 1'b0 || pass_a[k] !== 1'b0 || stim_a[k] !== 4'd0 ||
              err_a[k] !== 5'd0 || ffv_a[k] !== 4'd0 || ffm_a[k] !== 8'd0) begin
            errors++;
            $display("FAIL %s restart dut%0d: got busy=%b done=%b pass=%b stim=%0d err=%0d ffv=%0d ffm=%h, required 1 0 0 0 0 0 00",
                     name, k, busy_a[k], done_a[k], pass_a[k], stim_a[k], err_a[k], ffv_a[k], ffm_a[k]);
          end
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("reset");
    RST = 1'b0;
    @(posedge CLK); #1;
    check_idle("idle_no_start");
  endtask

  task automatic test_good_gate();
    mode = 0;
    run_and_check("good", 1'b0);
  endtask

  task automatic test_stuck_xor();
    mode = 1;
    run_and_check("stuck_xor", 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (err_a[k] !== 5'd8 || ffv_a[k] !== 4'd1 || ffm_a[k] !== 8'h10 || pass_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL stuck_xor_const dut%0d: got err=%0d ffv=%0d ffm=%h pass=%b, required 8 1 10 0",
                 k, err_a[k], ffv_a[k], ffm_a[k], pass_a[k]);
      end
    end
  endtask

  task automatic test_swap_67();
    mode = 2;
    run_and_check("swap67", 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (err_a[k] !== 5'd16 || ffv_a[k] !== 4'd0 || ffm_a[k] !== 8'hC0 || pass_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL swap67_const dut%0d: got err=%0d ffv=%0d ffm=%h pass=%b, required 16 0 c0 0",
                 k, err_a[k], ffv_a[k], ffm_a[k], pass_a[k]);
      end
    end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 16; v++) begin
        flip_tbl[v] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      mode = 3;
      run_and_check("random", 1'b0);
    end
    mode = 0;
  endtask

  task automatic test_mid_reset();
    mode = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    checks++;
    if (stim_a[1] !== 4'd7 || busy_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pos: got stim=%0d busy=%b, required 7 1", stim_a[1], busy_a[1]);
    end
    RST = 1'b1;
    start = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    start = 1'b0;
    check_idle("mid_reset");
    @(posedge CLK); #1;
    check_idle("mid_reset_hold");
    run_and_check("after_reset", 1'b0);
  endtask

  task automatic test_start_held();
    mode = 0;
    run_and_check("start_held", 1'b1);
    do_reset();
  endtask

  initial begin
    for (int v = 0; v < 16; v++) flip_tbl[v] = 8'h00;
    test_reset();
    test_good_gate();
    test_stuck_xor();
    test_swap_67();
    test_random_faults();
    test_mid_reset();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, is the number of cycles between a stimulus change and its response sample; legal range 0..15.
REQ-002 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port RST  input  1  reset; synchronous, active-high.
REQ-004 Port start  input  1  run request; sampled only in IDLE.
REQ-005 Port stim  output  4  drives gate inputs; stim[0]=in1, stim[1]=in2, stim[2]=in3, stim[3]=in4; registered.
REQ-006 Port resp  input  8  gate outputs under test; resp[k]=outk, k=0..7.
REQ-007 Port busy  output  1  high in SETTLE and SAMPLE.
REQ-008 Port done  output  1  high in DONE; held until the next accepted start or reset.
REQ-009 Port pass  output  1  high in DONE when err_count==0; low otherwise.
REQ-010 Port err_count  output  5  number of mismatching vectors in the current run, 0..16.
REQ-011 Port first_fail_vec  output  4  stim value of the first mismatching vector; 0 if none.
REQ-012 Port first_fail_mask  output  8  XOR of expected and resp at the first mismatch; 0 if none.

Function
REQ-013 Expected response for vector v (in1..in4 = v[0..3]): bit0 AND of all four; bit1 NAND; bit2 OR; bit3 NOR; bit4 XOR (odd parity); bit5 XNOR; bit6 NOT in1; bit7 in1.
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL enter SETTLE next cycle, with stim=0, err_count=0, first_fail_vec=0, first_fail_mask=0, and done/pass cleared.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles (zero cycles when SETTLE_CYCLES=0: go straight to SAMPLE), then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and compare resp with the expected value for the current stim.
REQ-018 On mismatch in SAMPLE, err_count SHALL increment; if err_count was 0, first_fail_vec and first_fail_mask SHALL capture the current stim and difference.
REQ-019 In SAMPLE with stim<15, stim SHALL increment and the FSM SHALL return to SETTLE; with stim==15, it SHALL go to DONE and stim SHALL hold at 15.
REQ-020 A full run SHALL take 16*(SETTLE_CYCLES+1) cycles from the first SETTLE/SAMPLE cycle to entry into DONE.
REQ-021 start while busy SHALL be ignored with no effect on the run.
REQ-022 err_count SHALL never wrap: at most 16 vectors are sampled per run.
REQ-023 Outputs SHALL depend only on registered state; there is no combinational path from resp or start to any output.

Reset
REQ-024 RST=1 SHALL force IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0 and first_fail_mask=0 on the next edge, including mid-run; a partial run is discarded.
REQ-025 RST SHALL take priority over start on the same edge.

Structure
REQ-026 Package gate_chk_pkg SHALL hold the state enum, N_VECTORS=16, and the resp bit-index constants (IDX_AND .. IDX_BUF).
REQ-027 Expected-value generation SHALL be a purely combinational sub-module gate_ref_model (4-bit in, 8-bit out) instantiated once.

Verification
REQ-028 Test 1: correct gate block attached, SETTLE_CYCLES=1, start pulse -> done after 32 cycles, pass=1, err_count=0, stim sequence 0..15 with each value held for 2 cycles.
REQ-029 Test 2: resp[4] stuck at 0 -> err_count=8, first_fail_vec=1, first_fail_mask=8'h10, pass=0.
REQ-030 Test 3: resp[6] and resp[7] swapped -> err_count=16, first_fail_vec=0, first_fail_mask=8'hC0; the vector-0 expected value is 8'h6A.
REQ-031 Test 4: RST pulsed at stim=7 mid-run -> next cycle IDLE with all outputs 0; a fresh start completes with pass=1.
REQ-032 Test 5: start held high through the run -> a single run completes, then a new run starts from DONE on the next cycle with counters cleared.
REQ-033 Test 6: SETTLE_CYCLES=0 and SETTLE_CYCLES=3 -> run lengths of 16 and 64 cycles, results identical to Test 1.
